aes_inv_control_unit: RTL

- Sequencer for the AES-128 inverse cipher (decryption datapath); the decrypt-side counterpart of the encrypt round controller.
- Drives the round-transformation units in inverse order: AddRoundKey, then InvShiftRows+InvSubBytes (ISS), AddRoundKey, InvMixColumns (IMC).
- Each unit is driven by a one-cycle start pulse and answers with a one-cycle ready pulse.
- Outputs the round-key index, so the key store is read last key first, plus the datapath mux selects.

---
 rtl/aes_inv_control_unit_if.sv | 45 ++++
 rtl/aes_inv_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_control_unit_if.sv
// ---------------------------------------------------------------------------
// aes_inv_control_unit_if
// Bundles the control/handshake signals of the AES-128 inverse-cipher
// sequencer.
//   master : the sequencer (drives start pulses, round index, mux selects,
//            status)
//   slave  : the datapath side (drives load/key-ready and unit ready pulses)
// Signals:
//   load_in, key_ready_in              request / key expansion complete
//   iss_ready_in, ark_ready_in,
//   imc_ready_in                       unit completion pulses
//   iss_start_out, ark_start_out,
//   imc_start_out                      unit start pulses
//   round_out[3:0]                     round / round-key index
//   ark_in_sel[2:0], iss_in_sel        datapath mux selects
//   busy_out, done_out, error_out      status
// ---------------------------------------------------------------------------
interface aes_inv_control_unit_if;
   logic       load_in;
   logic       key_ready_in;
   logic       iss_ready_in;
   logic       ark_ready_in;
   logic       imc_ready_in;
   logic       iss_start_out;
   logic       ark_start_out;
   logic       imc_start_out;
   logic [3:0] round_out;
   logic [2:0] ark_in_sel;
   logic       iss_in_sel;
   logic       busy_out;
   logic       done_out;
   logic       error_out;

   modport master (
      input  load_in, key_ready_in, iss_ready_in, ark_ready_in, imc_ready_in,
      output iss_start_out, ark_start_out, imc_start_out, round_out,
             ark_in_sel, iss_in_sel, busy_out, done_out, error_out
   );

   modport slave (
      output load_in, key_ready_in, iss_ready_in, ark_ready_in, imc_ready_in,
      input  iss_start_out, ark_start_out, imc_start_out, round_out,
             ark_in_sel, iss_in_sel, busy_out, done_out, error_out
   );
endinterface

// File: rtl/aes_inv_control_unit.sv
// ---------------------------------------------------------------------------
// aes_inv_control_unit
// Sequencer for the AES-128 inverse cipher. Walks the round keys from NR
// down to 0, driving AddRoundKey (ARK), InvShiftRows+InvSubBytes (ISS) and
// InvMixColumns (IMC) in inverse order:
//   ARK(NR), then for r = NR-1..1: ISS, ARK(r), IMC; then ISS, ARK(0), done.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   bus        aes_inv_control_unit_if.master (handshakes, round, selects,
//              status)
//   state_dbg  current FSM state (IDLE=0, WAIT_KEY=1, ARK=2, ISS=3, IMC=4,
//              DONE=5)
// Optional feature: define AES_DEC_TIMEOUT_EN to build a watchdog that
// aborts a unit wait after TIMEOUT_CYCLES cycles and pulses error_out.
// Without it error_out is tied to 0 and waits are unbounded.
//
// Handshake: each unit gets a registered start pulse, high for exactly one
// cycle in the first cycle of the state that waits on it. The unit answers
// with a one-cycle ready pulse. Only the ready of the awaited unit is
// accepted, and only in a cycle after its start pulse; all others are
// ignored.
// ---------------------------------------------------------------------------
module aes_inv_control_unit #(
   parameter int NR = 10
`ifdef AES_DEC_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   aes_inv_control_unit_if.master       bus,
   output logic [2:0]                   state_dbg
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_KEY = 3'd1;
   localparam logic [2:0] S_ARK      = 3'd2;
   localparam logic [2:0] S_ISS      = 3'd3;
   localparam logic [2:0] S_IMC      = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0] state_q;
   logic       ark_start_q, iss_start_q, imc_start_q;
   logic [3:0] round_q;
   logic [2:0] ark_sel_q;
   logic       iss_sel_q;
   logic       busy_q, done_q;
   logic       accept;

   // The awaited unit's ready, qualified so the start cycle never counts.
   always_comb begin
      accept = 1'b0;
      case (state_q)
         S_ARK:   accept = bus.ark_ready_in && !ark_start_q;
         S_ISS:   accept = bus.iss_ready_in && !iss_start_q;
         S_IMC:   accept = bus.imc_ready_in && !imc_start_q;
         default: accept = 1'b0;
      endcase
   end

`ifdef AES_DEC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q;
   logic          error_q;
   logic          waiting;
   logic          any_start;

   assign waiting   = (state_q == S_ARK) || (state_q == S_ISS) || (state_q == S_IMC);
   assign any_start = ark_start_q || iss_start_q || imc_start_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ark_start_q <= 1'b0;
         iss_start_q <= 1'b0;
         imc_start_q <= 1'b0;
         round_q     <= 4'd0;
         ark_sel_q   <= 3'b000;
         iss_sel_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef AES_DEC_TIMEOUT_EN
         timer_q     <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         ark_start_q <= 1'b0;
         iss_start_q <= 1'b0;
         imc_start_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef AES_DEC_TIMEOUT_EN
         error_q     <= 1'b0;
`endif
         case (state_q)
            S_IDLE, S_WAIT_KEY: begin
               if (state_q == S_WAIT_KEY || bus.load_in) begin
                  busy_q <= 1'b1;
                  if (bus.key_ready_in) begin
                     state_q     <= S_ARK;
                     round_q     <= 4'(NR);
                     ark_sel_q   <= 3'b001;
                     iss_sel_q   <= 1'b1;
                     ark_start_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT_KEY;
                  end
               end
            end
            S_ARK: begin
               if (accept) begin
                  if (round_q == 4'(NR)) begin
                     // Initial key add done; first inverse round reads ARK output.
                     round_q     <= 4'(NR - 1);
                     iss_sel_q   <= 1'b0;
                     state_q     <= S_ISS;
                     iss_start_q <= 1'b1;
                  end else if (round_q == 4'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q     <= S_IMC;
                     imc_start_q <= 1'b1;
                  end
               end
            end
            S_ISS: begin
               if (accept) begin
                  state_q     <= S_ARK;
                  ark_sel_q   <= 3'b010;
                  ark_start_q <= 1'b1;
               end
            end
            S_IMC: begin
               if (accept) begin
                  // round_q >= 1 here, so the decrement cannot wrap.
                  round_q     <= round_q - 4'd1;
                  iss_sel_q   <= ((round_q - 4'd1) != 4'(NR - 1));
                  state_q     <= S_ISS;
                  iss_start_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q   <= S_IDLE;
               round_q   <= 4'd0;
               iss_sel_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef AES_DEC_TIMEOUT_EN
         // timer_q counts cycles since the last start pulse (1 in the cycle
         // after it). A ready in the limit cycle is accepted above instead.
         if (any_start) begin
            timer_q <= TW'(1);
         end else if (timer_q != TW'(TIMEOUT_CYCLES)) begin
            timer_q <= timer_q + TW'(1);
         end
         if (waiting && !any_start && !accept && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
         end
`endif
      end
   end

   assign bus.ark_start_out = ark_start_q;
   assign bus.iss_start_out = iss_start_q;
   assign bus.imc_start_out = imc_start_q;
   assign bus.round_out     = round_q;
   assign bus.ark_in_sel    = ark_sel_q;
   assign bus.iss_in_sel    = iss_sel_q;
   assign bus.busy_out      = busy_q;
   assign bus.done_out      = done_q;
`ifdef AES_DEC_TIMEOUT_EN
   assign bus.error_out     = error_q;
`else
   assign bus.error_out     = 1'b0;
`endif
   assign state_dbg         = state_q;

endmodule
